// File: rtl/nic_flit_injector_if.sv
// Flit source handshake between a NIC source and nic_flit_injector.
interface nic_flit_injector_if #(
    parameter int num_vcs         = 2,
    parameter int flit_data_width = 64
);
    localparam int vc_idx_width = (num_vcs > 1) ? $clog2(num_vcs) : 1;

    logic                       in_valid;
    logic                       in_ready;
    logic                       in_head;
    logic                       in_tail;
    logic [vc_idx_width-1:0]    in_vc;
    logic [flit_data_width-1:0] in_data;

    modport master (output in_valid, in_head, in_tail, in_vc, in_data, input in_ready);
    modport slave  (input in_valid, in_head, in_tail, in_vc, in_data, output in_ready);
endinterface

// File: rtl/nic_flit_injector.sv
// Credit-based flit injector feeding one router input port with per-VC credit tracking.
// Optional protocol checking is built when NIC_INJ_ERROR_CHECK_EN is defined.
module nic_flit_injector #(
    parameter int num_vcs         = 2,
    parameter int buffer_size     = 16,
    parameter int flit_data_width = 64,
    localparam int vc_idx_width   = (num_vcs > 1) ? $clog2(num_vcs) : 1,
    localparam int vc_depth       = buffer_size / num_vcs,
    localparam int credit_width   = $clog2(vc_depth + 1),
    localparam int chan_width     = 3 + vc_idx_width + flit_data_width
) (
    input  logic                    clk,
    input  logic                    reset,
    nic_flit_injector_if.slave      src,
    output logic [chan_width-1:0]   channel_out,
    input  logic [vc_idx_width:0]   flow_ctrl_in,
    output logic                    error
);
    typedef logic [credit_width-1:0] credit_t;
    typedef enum logic {IDLE, BUSY} state_t;

    localparam credit_t credit_max = credit_t'(vc_depth);

    // Simultaneous take and return cancel; a return at max saturates.
    function automatic credit_t credit_update(credit_t cur, logic dec, logic inc);
        credit_t nxt;
        nxt = cur;
        if (dec && !inc)
            nxt = cur - credit_t'(1);
        else if (inc && !dec && cur != credit_max)
            nxt = cur + credit_t'(1);
        return nxt;
    endfunction

    state_t                     state_q, state_d;
    logic [vc_idx_width-1:0]    locked_vc_q, locked_vc_d;
    logic [vc_idx_width-1:0]    sel_vc;
    credit_t                    credit_q [num_vcs];
    credit_t                    credit_d [num_vcs];
    logic                       accept;
    logic                       ret_vld;
    logic [vc_idx_width-1:0]    ret_vc;

    logic                       vld_p1;
    logic [vc_idx_width-1:0]    vc_p1;
    logic                       head_p1;
    logic                       tail_p1;
    logic [flit_data_width-1:0] data_p1;

    assign ret_vld      = flow_ctrl_in[vc_idx_width];
    assign ret_vc       = flow_ctrl_in[vc_idx_width-1:0];
    assign sel_vc       = (state_q == BUSY) ? locked_vc_q : src.in_vc;
    assign src.in_ready = (credit_q[sel_vc] != '0);
    assign accept       = src.in_valid && src.in_ready;

    always_comb begin
        state_d     = state_q;
        locked_vc_d = locked_vc_q;
        case (state_q)
            IDLE: begin
                if (accept && src.in_head && !src.in_tail) begin
                    state_d     = BUSY;
                    locked_vc_d = src.in_vc;
                end
            end
            BUSY: begin
                if (accept && src.in_tail)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int v = 0; v < num_vcs; v++) begin
            credit_d[v] = credit_update(credit_q[v],
                                        accept && (sel_vc == vc_idx_width'(v)),
                                        ret_vld && (ret_vc == vc_idx_width'(v)));
        end
    end

    // Stage p0 -> p1: control state and output valid
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            locked_vc_q <= '0;
            vld_p1      <= 1'b0;
            for (int v = 0; v < num_vcs; v++)
                credit_q[v] <= credit_max;
        end else begin
            state_q     <= state_d;
            locked_vc_q <= locked_vc_d;
            vld_p1      <= accept;
            for (int v = 0; v < num_vcs; v++)
                credit_q[v] <= credit_d[v];
        end
    end

    // Stage p0 -> p1: flit fields, only meaningful alongside vld_p1
    always_ff @(posedge clk) begin
        if (accept) begin
            vc_p1   <= sel_vc;
            head_p1 <= src.in_head;
            tail_p1 <= src.in_tail;
            data_p1 <= src.in_data;
        end
    end

    assign channel_out = {vld_p1, vc_p1, head_p1, tail_p1, data_p1};

`ifdef NIC_INJ_ERROR_CHECK_EN
    logic overflow;
    logic framing_err;
    logic error_q;

    assign overflow    = ret_vld && (credit_q[ret_vc] == credit_max) &&
                         !(accept && (sel_vc == ret_vc));
    assign framing_err = accept && (((state_q == IDLE) && !src.in_head) ||
                                    ((state_q == BUSY) && src.in_head));

    always_ff @(posedge clk) begin
        if (reset)
            error_q <= 1'b0;
        else if (overflow || framing_err)
            error_q <= 1'b1;
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_nic_flit_injector.sv
// Randomized and directed bench for nic_flit_injector against a packet-level credit model.
module tb_nic_flit_injector;
    localparam int NV   = 2;
    localparam int BS   = 16;
    localparam int DW   = 64;
    localparam int VCW  = 1;
    localparam int CW   = 3 + VCW + DW;
    localparam int MAXC = BS / NV;
`ifdef NIC_INJ_ERROR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] channel_out;
    logic [VCW:0]  flow_ctrl_in = '0;
    logic          error;

    nic_flit_injector_if #(.num_vcs(NV), .flit_data_width(DW)) ifc ();

    nic_flit_injector #(.num_vcs(NV), .buffer_size(BS), .flit_data_width(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .src          (ifc),
        .channel_out  (channel_out),
        .flow_ctrl_in (flow_ctrl_in),
        .error        (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: credits per VC, open-packet flag and its VC, sticky error.
    int cred [NV];
    bit open_m;
    int lvc_m;
    bit err_m;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) cred[v] = MAXC;
        open_m = 1'b0;
        lvc_m  = 0;
        err_m  = 1'b0;
    endtask

    task automatic cycle(input bit v, input bit h, input bit t, input int vc,
                         input logic [DW-1:0] d, input bit fv, input int fvc, output bit acc);
        int            sel;
        bit            rdy;
        logic [CW-1:0] exp_ch;
        @(negedge clk);
        ifc.in_valid = v;
        ifc.in_head  = h;
        ifc.in_tail  = t;
        ifc.in_vc    = VCW'(vc);
        ifc.in_data  = d;
        flow_ctrl_in = {fv, VCW'(fvc)};
        sel = open_m ? lvc_m : vc;
        rdy = (cred[sel] > 0);
        #1 check_val("in_ready", ifc.in_ready, rdy);
        @(posedge clk);
        #1;
        acc = v && rdy;
        if (acc && !open_m && !h) err_m = 1'b1;
        if (acc && open_m && h) err_m = 1'b1;
        if (fv && cred[fvc] == MAXC && !(acc && sel == fvc)) err_m = 1'b1;
        if (acc) cred[sel] = cred[sel] - 1;
        if (fv) cred[fvc] = (cred[fvc] < MAXC) ? cred[fvc] + 1 : MAXC;
        if (acc) begin
            if (!open_m && h && !t) begin
                open_m = 1'b1;
                lvc_m  = vc;
            end else if (open_m && t) begin
                open_m = 1'b0;
            end
        end
        check_val("out_valid", channel_out[CW-1], acc);
        if (acc) begin
            exp_ch = {1'b1, VCW'(sel), h, t, d};
            check_val("out_flit", channel_out, exp_ch);
        end
        check_val("error", error, ERR_EN ? err_m : 1'b0);
    endtask

    task automatic send(input bit h, input bit t, input int vc, input logic [DW-1:0] d);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            cycle(1'b1, h, t, vc, d, 1'b0, 0, acc);
            tries++;
        end
        if (!acc) check_val("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic apply_reset(input bit v);
        @(negedge clk);
        reset = 1'b1;
        ifc.in_valid = v;
        flow_ctrl_in = '0;
        @(posedge clk);
        #1;
        model_reset();
        check_val("rst_valid", channel_out[CW-1], 1'b0);
        check_val("rst_error", error, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        ifc.in_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit pend, ph, pt, v, fv;
        int pvc, fvc;
        logic [DW-1:0] pd;

        ifc.in_valid = 1'b0;
        ifc.in_head  = 1'b0;
        ifc.in_tail  = 1'b0;
        ifc.in_vc    = '0;
        ifc.in_data  = '0;
        model_reset();

        // 3-flit packet on VC1, then drain the remaining 5 credits
        apply_reset(1'b0);
        send(1'b1, 1'b0, 1, 64'h0000_0000_0000_00A0);
        send(1'b0, 1'b0, 0, 64'h0000_0000_0000_00B0);
        send(1'b0, 1'b1, 0, 64'h0000_0000_0000_00C0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 1, rnd_data(), 1'b0, 0, acc);

        // nine single flits on VC0, one credit return releases the ninth
        apply_reset(1'b0);
        pd = rnd_data();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b1, 0, rnd_data(), 1'b0, 0, acc);
        cycle(1'b1, 1'b1, 1'b1, 0, pd, 1'b0, 0, acc);
        cycle(1'b1, 1'b1, 1'b1, 0, pd, 1'b1, 0, acc);
        cycle(1'b1, 1'b1, 1'b1, 0, pd, 1'b0, 0, acc);

        // VC0 starved; VC1 traffic still flows
        apply_reset(1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b1, 0, rnd_data(), 1'b0, 0, acc);
        send(1'b1, 1'b0, 0, rnd_data());
        pd = rnd_data();
        cycle(1'b1, 1'b0, 1'b1, 1, pd, 1'b0, 0, acc);
        cycle(1'b1, 1'b0, 1'b1, 1, pd, 1'b0, 0, acc);
        cycle(1'b1, 1'b0, 1'b1, 1, pd, 1'b1, 0, acc);
        cycle(1'b1, 1'b0, 1'b1, 1, pd, 1'b0, 0, acc);
        cycle(1'b1, 1'b1, 1'b1, 0, pd, 1'b0, 0, acc);
        cycle(1'b1, 1'b1, 1'b1, 0, pd, 1'b0, 0, acc);
        cycle(1'b1, 1'b1, 1'b1, 1, rnd_data(), 1'b0, 0, acc);
        cycle(1'b1, 1'b1, 1'b1, 0, pd, 1'b0, 0, acc);

        // take and return on VC1 in the same cycle at credit 4
        apply_reset(1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1, rnd_data(), 1'b0, 0, acc);
        cycle(1'b1, 1'b1, 1'b1, 1, rnd_data(), 1'b1, 1, acc);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1, rnd_data(), 1'b0, 0, acc);

        // credit return at max, then a body flit while idle
        apply_reset(1'b0);
        cycle(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 0, acc);
        cycle(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0, acc);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b1, 0, rnd_data(), 1'b0, 0, acc);
        apply_reset(1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1, rnd_data(), 1'b0, 0, acc);
        cycle(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0, acc);
        cycle(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0, acc);

        // reset in the middle of a 4-flit VC1 packet
        apply_reset(1'b0);
        send(1'b1, 1'b0, 1, rnd_data());
        send(1'b0, 1'b0, 1, rnd_data());
        apply_reset(1'b1);
        cycle(1'b1, 1'b1, 1'b1, 0, rnd_data(), 1'b0, 0, acc);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b1, 1, rnd_data(), 1'b0, 0, acc);

        // randomized legal traffic with random credit returns
        apply_reset(1'b0);
        pend = 1'b0;
        ph = 1'b0;
        pt = 1'b0;
        pvc = 0;
        pd = '0;
        for (int i = 0; i < 500; i++) begin
            if (!pend) begin
                ph   = !open_m;
                pt   = ($urandom_range(0, 2) == 0);
                pvc  = $urandom_range(0, NV - 1);
                pd   = rnd_data();
                pend = 1'b1;
            end
            v   = ($urandom_range(0, 3) != 0);
            fvc = $urandom_range(0, NV - 1);
            fv  = ($urandom_range(0, 2) == 0) && (cred[fvc] < MAXC);
            cycle(v, ph, pt, pvc, pd, fv, fvc, acc);
            if (acc) pend = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nic_flit_injector.md
NIC_FLIT_INJECTOR -- requirements
Module: nic_flit_injector

Interface
REQ-001 SHALL have parameter num_vcs, default 2: number of VCs on the router input port fed by this block.
REQ-002 SHALL have parameter buffer_size, default 16: total router input buffer entries, split evenly so each VC holds buffer_size/num_vcs entries.
REQ-003 SHALL have parameter flit_data_width, default 64: flit payload width.
REQ-004 SHALL derive vc_idx_width = clogb(num_vcs) and credit_width = clogb(buffer_size/num_vcs + 1).
REQ-005 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: source flit offered.
REQ-008 SHALL have port in_ready, output, 1: flit accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_head, input, 1, and port in_tail, input, 1: flit framing; a single-flit packet has both set.
REQ-010 SHALL have port in_vc, input, vc_idx_width: target VC, sampled on head flits only.
REQ-011 SHALL have port in_data, input, flit_data_width: flit payload.
REQ-012 SHALL have port channel_out, output, 1+vc_idx_width+1+1+flit_data_width: router input channel with fields {valid, vc, head, tail, data}, MSB first.
REQ-013 SHALL have port flow_ctrl_in, input, 1+vc_idx_width: credit return from the router as {valid, vc}.
REQ-014 SHALL have port error, output, 1: sticky protocol error.

Function
REQ-015 SHALL keep one credit counter per VC, ranging 0..buffer_size/num_vcs.
REQ-016 SHALL use a two-state FSM: IDLE (no open packet) and BUSY (packet open on locked_vc).
REQ-017 SHALL set sel_vc to in_vc in IDLE and to locked_vc in BUSY.
REQ-018 SHALL drive in_ready combinationally high iff credit[sel_vc] != 0; it SHALL have no combinational dependence on flow_ctrl_in.
REQ-019 On acceptance, SHALL register the flit and present it on channel_out with valid=1 in the next cycle only (latency 1, one-cycle pulse); when nothing is accepted, channel_out valid SHALL be 0 and the other fields SHALL be don't-care.
REQ-020 In IDLE, a head flit with tail=0 SHALL load locked_vc with in_vc and go to BUSY; a head flit with tail=1 SHALL stay in IDLE.
REQ-021 In BUSY, an accepted tail flit SHALL return the FSM to IDLE; in_vc SHALL be ignored.
REQ-022 Acceptance SHALL decrement credit[sel_vc]; a valid flow_ctrl_in SHALL increment credit[vc].
REQ-023 A decrement and an increment on the same VC in the same cycle SHALL leave that counter unchanged.
REQ-024 A credit return to a counter already at max SHALL leave the counter saturated at max and SHALL flag an error.
REQ-025 Throughput SHALL be one flit per cycle while credits are available; a counter at 0 SHALL stall only while sel_vc is that VC.

Reset
REQ-026 Reset SHALL set every credit counter to buffer_size/num_vcs, the FSM to IDLE, locked_vc to 0, channel_out valid to 0, and error to 0.
REQ-027 A reset asserted mid-packet SHALL abandon the open packet; the first flit after reset is treated per IDLE rules, and no flit SHALL be emitted in the cycle after the reset cycle.

Configuration
REQ-028 With macro NIC_INJ_ERROR_CHECK_EN defined, error SHALL set sticky, until reset, on any of: credit overflow (REQ-024); a non-head flit accepted in IDLE; a head flit accepted in BUSY.
REQ-029 With NIC_INJ_ERROR_CHECK_EN undefined, error SHALL be constant 0 and no checking logic SHALL be built; credit saturation per REQ-024 is still required.

Verification
REQ-030 Reset, then a 3-flit packet on VC1 with data A, B, C -> channel_out emits head/A, B, tail/C on VC1 in consecutive cycles; credit[1] goes 8->5.
REQ-031 Nine back-to-back single-flit packets on VC0 with no credit return -> 8 are accepted, then in_ready=0; one credit return on VC0 -> the ninth is accepted the next cycle.
REQ-032 Credit[0]=0 with a VC0 packet stalled, plus a VC1 head offered after that packet's tail -> the VC1 flit is accepted while VC0 stays stalled.
REQ-033 Accept on VC1 and credit return on VC1 in the same cycle with credit[1]=4 -> credit[1] stays 4.
REQ-034 With NIC_INJ_ERROR_CHECK_EN defined, a credit return with credit at max, or a body flit in IDLE -> error=1 from the next cycle until reset; with the macro undefined -> error stays 0 and the counter stays at 8.
REQ-035 Reset asserted after the head of a 4-flit packet -> FSM returns to IDLE, all credits return to 8, and channel_out valid=0 in the cycle after the reset cycle.
